// File: rtl/dual_issue_ctrl_pkg.sv
// Shared definitions for the dual-issue controller: unit IDs, odd-pipe
// predicate, latency limits and scoreboard geometry.
//
// Contents:
//   unit_e       - execution unit IDs (0..4 even pipe, 5..7 odd pipe)
//   is_odd_pipe  - true when a unit ID belongs to the odd pipe
//   norm_lat     - clamps an out-of-range latency (0 or >7) to MaxLat
package dual_issue_ctrl_pkg;

    localparam int unsigned NumRegs = 128;
    localparam int unsigned RegW    = 7;
    localparam int unsigned CntW    = 4;
    localparam int unsigned LatW    = 4;
    localparam int unsigned MaxLat  = 7;
    localparam int unsigned NumRd   = 6;
    localparam int unsigned NumLd   = 2;

    typedef logic [RegW-1:0] reg_idx_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [LatW-1:0] lat_t;
    typedef logic [2:0]      unit_t;

    typedef enum logic [2:0] {
        UnitFx0  = 3'b000,
        UnitFx1  = 3'b001,
        UnitFx2  = 3'b010,
        UnitFp0  = 3'b011,
        UnitFp1  = 3'b100,
        UnitBr   = 3'b101,
        UnitLs   = 3'b110,
        UnitPerm = 3'b111
    } unit_e;

    function automatic logic is_odd_pipe(unit_t u);
        return (u == UnitBr) || (u == UnitLs) || (u == UnitPerm);
    endfunction

    // Latencies outside 1..MaxLat are treated as the worst case.
    function automatic lat_t norm_lat(lat_t l);
        if (l == '0 || l > lat_t'(MaxLat)) begin
            return lat_t'(MaxLat);
        end
        return l;
    endfunction

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Issue-slot bundle between the decode stage and the dual-issue controller.
//
// Signals:
//   i1_* / i2_*   - older / younger instruction slot: valid, unit, sources
//                   (ra/rb/rc with *_use), destination, write enable, latency
//   flush         - taken-branch flush from the odd pipe
//   issue1/2      - slot issued this cycle; issue2_to_odd routes i2
//   stall         - valid i1 held this cycle; stall_cnt saturating count
// Modports: master (decode side), slave (controller side).
interface dual_issue_ctrl_if;
    import dual_issue_ctrl_pkg::*;

    logic     i1_valid,  i2_valid;
    unit_t    i1_unit,   i2_unit;
    reg_idx_t i1_ra,     i1_rb,     i1_rc;
    reg_idx_t i2_ra,     i2_rb,     i2_rc;
    logic     i1_ra_use, i1_rb_use, i1_rc_use;
    logic     i2_ra_use, i2_rb_use, i2_rc_use;
    reg_idx_t i1_dst,    i2_dst;
    logic     i1_wr,     i2_wr;
    lat_t     i1_lat,    i2_lat;
    logic     flush;

    logic        issue1;
    logic        issue2;
    logic        issue2_to_odd;
    logic        stall;
    logic [31:0] stall_cnt;

    modport master (
        output i1_valid, i2_valid, i1_unit, i2_unit,
        output i1_ra, i1_rb, i1_rc, i2_ra, i2_rb, i2_rc,
        output i1_ra_use, i1_rb_use, i1_rc_use, i2_ra_use, i2_rb_use, i2_rc_use,
        output i1_dst, i2_dst, i1_wr, i2_wr, i1_lat, i2_lat, flush,
        input  issue1, issue2, issue2_to_odd, stall, stall_cnt
    );

    modport slave (
        input  i1_valid, i2_valid, i1_unit, i2_unit,
        input  i1_ra, i1_rb, i1_rc, i2_ra, i2_rb, i2_rc,
        input  i1_ra_use, i1_rb_use, i1_rc_use, i2_ra_use, i2_rb_use, i2_rc_use,
        input  i1_dst, i2_dst, i1_wr, i2_wr, i1_lat, i2_lat, flush,
        output issue1, issue2, issue2_to_odd, stall, stall_cnt
    );

endinterface

// File: rtl/dual_issue_ctrl_scoreboard.sv
// Register-readiness scoreboard: one countdown counter per register.
// A counter holds the number of cycles until its register may be read;
// zero means ready. Every nonzero counter decrements each cycle unless
// it is being loaded.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (all counters to 0)
//   rd_addr   - six source read addresses; rd_ready - counter is zero
//   ld_en     - two load ports; ld_addr/ld_lat - target and latency (1..7)
//   ld_cur    - current counter at each load address (for WAW checking)
module dual_issue_ctrl_scoreboard
    import dual_issue_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NumRd-1:0][RegW-1:0] rd_addr,
    output logic [NumRd-1:0]           rd_ready,
    input  logic [NumLd-1:0]           ld_en,
    input  logic [NumLd-1:0][RegW-1:0] ld_addr,
    input  logic [NumLd-1:0][LatW-1:0] ld_lat,
    output logic [NumLd-1:0][CntW-1:0] ld_cur
);

    cnt_t cnt_q [NumRegs];
    cnt_t cnt_d [NumRegs];

    // A producer issued in cycle t with latency L must let its consumer go
    // in cycle t+L. The counter is first visible in t+1, so it is loaded
    // with L-1 to reach zero exactly in t+L.
    always_comb begin
        for (int r = 0; r < NumRegs; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - cnt_t'(1) : '0;
            for (int p = 0; p < NumLd; p++) begin
                if (ld_en[p] && ld_addr[p] == RegW'(r)) begin
                    cnt_d[r] = cnt_t'(ld_lat[p]) - cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NumRegs; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NumRegs; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumRd; p++) begin
            rd_ready[p] = (cnt_q[rd_addr[p]] == '0);
        end
        for (int p = 0; p < NumLd; p++) begin
            ld_cur[p] = cnt_q[ld_addr[p]];
        end
    end

endmodule

// File: rtl/dual_issue_ctrl.sv
// In-order dual-issue controller. Decides each cycle whether the older slot
// (i1) and, only together with it, the younger slot (i2) issue, based on
// register readiness, WAW ordering, pipe assignment and intra-pair hazards.
// Holds no instruction state; an unissued i2 is re-presented as i1.
//
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - dual_issue_ctrl_if.slave: slot fields, flush, issue results,
//              stall and saturating stall_cnt
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    dual_issue_ctrl_if.slave bus
);

    logic [NumRd-1:0][RegW-1:0] rd_addr;
    logic [NumRd-1:0]           rd_ready;
    logic [NumLd-1:0]           ld_en;
    logic [NumLd-1:0][RegW-1:0] ld_addr;
    logic [NumLd-1:0][LatW-1:0] ld_lat;
    logic [NumLd-1:0][CntW-1:0] ld_cur;

    lat_t i1_lat_n, i2_lat_n;
    logic i1_src_ok, i2_src_ok;
    logic i1_waw_ok, i2_waw_ok;
    logic i1_odd, i2_odd;
    logic i2_raw_hit, i2_dst_hit;
    logic issue1, issue2, stall;

    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign rd_addr = {bus.i2_rc, bus.i2_rb, bus.i2_ra, bus.i1_rc, bus.i1_rb, bus.i1_ra};

    always_comb begin
        i1_lat_n = norm_lat(bus.i1_lat);
        i2_lat_n = norm_lat(bus.i2_lat);

        i1_src_ok = (!bus.i1_ra_use || rd_ready[0]) &&
                    (!bus.i1_rb_use || rd_ready[1]) &&
                    (!bus.i1_rc_use || rd_ready[2]);
        i2_src_ok = (!bus.i2_ra_use || rd_ready[3]) &&
                    (!bus.i2_rb_use || rd_ready[4]) &&
                    (!bus.i2_rc_use || rd_ready[5]);

        // A new write may not complete before an older in-flight one.
        i1_waw_ok = !bus.i1_wr || (ld_cur[0] <= cnt_t'(i1_lat_n));
        i2_waw_ok = !bus.i2_wr || (ld_cur[1] <= cnt_t'(i2_lat_n));

        i1_odd = is_odd_pipe(bus.i1_unit);
        i2_odd = is_odd_pipe(bus.i2_unit);

        i2_raw_hit = bus.i1_wr &&
                     ((bus.i2_ra_use && bus.i2_ra == bus.i1_dst) ||
                      (bus.i2_rb_use && bus.i2_rb == bus.i1_dst) ||
                      (bus.i2_rc_use && bus.i2_rc == bus.i1_dst));
        i2_dst_hit = bus.i1_wr && bus.i2_wr && (bus.i1_dst == bus.i2_dst);

        issue1 = bus.i1_valid && !bus.flush && i1_src_ok && i1_waw_ok;
        issue2 = issue1 && bus.i2_valid && i2_src_ok && i2_waw_ok &&
                 (i1_odd != i2_odd) && !i2_raw_hit && !i2_dst_hit;
        stall  = bus.i1_valid && !issue1 && !bus.flush;
    end

    // Flush suppresses issue, so no load happens and countdown continues.
    assign ld_en   = {issue2 && bus.i2_wr, issue1 && bus.i1_wr};
    assign ld_addr = {bus.i2_dst, bus.i1_dst};
    assign ld_lat  = {i2_lat_n, i1_lat_n};

    dual_issue_ctrl_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_lat   (ld_lat),
        .ld_cur   (ld_cur)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.issue1        = issue1;
    assign bus.issue2        = issue2;
    assign bus.issue2_to_odd = i2_odd;
    assign bus.stall         = stall;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed vector table, multi-cycle sequences
// and a randomized run against a ready-time reference model.
module tb_dual_issue_ctrl;

    typedef struct {
        logic       valid;
        logic [2:0] unit;
        logic [6:0] ra, rb, rc;
        logic       ra_use, rb_use, rc_use;
        logic [6:0] dst;
        logic       wr;
        logic [3:0] lat;
    } slot_t;

    typedef struct {
        slot_t s1, s2;
        logic  flush;
        logic  e1, e2, eodd, est;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_issue_ctrl_if bus ();

    dual_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: absolute cycle at which each register becomes readable.
    int     rdy [128];
    int     cyc = 0;
    longint scnt = 0;
    slot_t  cur1, cur2;
    logic   cur_flush;
    bit     m1, m2, modd, mstall;

    task automatic chk(string nm, logic [32:0] act, logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic slot_t mk(logic v, logic [2:0] u, logic [6:0] dst, logic wr,
                                 logic [3:0] lat, logic [6:0] ra, logic rau,
                                 logic [6:0] rb, logic rbu, logic [6:0] rc, logic rcu);
        slot_t s;
        s.valid = v; s.unit = u; s.dst = dst; s.wr = wr; s.lat = lat;
        s.ra = ra; s.ra_use = rau; s.rb = rb; s.rb_use = rbu; s.rc = rc; s.rc_use = rcu;
        return s;
    endfunction

    function automatic int rem(logic [6:0] r);
        return (rdy[r] > cyc) ? rdy[r] - cyc : 0;
    endfunction

    function automatic int nlat(logic [3:0] l);
        return (l == 0 || l > 7) ? 7 : int'(l);
    endfunction

    function automatic bit odd(logic [2:0] u);
        return u >= 3'd5;
    endfunction

    function automatic bit src_ok(slot_t s);
        return (!s.ra_use || rem(s.ra) == 0) && (!s.rb_use || rem(s.rb) == 0) &&
               (!s.rc_use || rem(s.rc) == 0);
    endfunction

    function automatic bit reads(slot_t s, logic [6:0] r);
        return (s.ra_use && s.ra == r) || (s.rb_use && s.rb == r) || (s.rc_use && s.rc == r);
    endfunction

    task automatic model_eval();
        m1 = cur1.valid && !cur_flush && src_ok(cur1) &&
             (!cur1.wr || rem(cur1.dst) <= nlat(cur1.lat));
        m2 = m1 && cur2.valid && src_ok(cur2) &&
             (!cur2.wr || rem(cur2.dst) <= nlat(cur2.lat)) &&
             (odd(cur1.unit) != odd(cur2.unit)) &&
             !(cur1.wr && reads(cur2, cur1.dst)) &&
             !(cur1.wr && cur2.wr && cur1.dst == cur2.dst);
        modd   = odd(cur2.unit);
        mstall = cur1.valid && !m1 && !cur_flush;
    endtask

    task automatic model_advance();
        if (m1 && cur1.wr) rdy[cur1.dst] = cyc + nlat(cur1.lat);
        if (m2 && cur2.wr) rdy[cur2.dst] = cyc + nlat(cur2.lat);
        if (mstall && scnt < 64'hFFFF_FFFF) scnt++;
        cyc++;
    endtask

    task automatic drive(slot_t a, slot_t b, logic fl);
        cur1 = a; cur2 = b; cur_flush = fl;
        bus.i1_valid = a.valid; bus.i1_unit = a.unit; bus.i1_dst = a.dst;
        bus.i1_wr = a.wr; bus.i1_lat = a.lat;
        bus.i1_ra = a.ra; bus.i1_rb = a.rb; bus.i1_rc = a.rc;
        bus.i1_ra_use = a.ra_use; bus.i1_rb_use = a.rb_use; bus.i1_rc_use = a.rc_use;
        bus.i2_valid = b.valid; bus.i2_unit = b.unit; bus.i2_dst = b.dst;
        bus.i2_wr = b.wr; bus.i2_lat = b.lat;
        bus.i2_ra = b.ra; bus.i2_rb = b.rb; bus.i2_rc = b.rc;
        bus.i2_ra_use = b.ra_use; bus.i2_rb_use = b.rb_use; bus.i2_rc_use = b.rc_use;
        bus.flush = fl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        foreach (rdy[i]) rdy[i] = 0;
        scnt = 0;
    endtask

    // Compare against hand-derived constants; ecnt < 0 skips stall_cnt.
    task automatic tick_hand(string nm, logic e1, logic e2, logic eodd, logic est, int ecnt);
        @(negedge clk);
        model_eval();
        chk({nm, ".issue1"}, bus.issue1, e1);
        chk({nm, ".issue2"}, bus.issue2, e2);
        chk({nm, ".stall"}, bus.stall, est);
        if (e2) chk({nm, ".to_odd"}, bus.issue2_to_odd, eodd);
        if (ecnt >= 0) chk({nm, ".stall_cnt"}, {1'b0, bus.stall_cnt}, ecnt);
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic tick_model(int i);
        string nm;
        nm = $sformatf("rnd%0d", i);
        @(negedge clk);
        model_eval();
        chk({nm, ".issue1"}, bus.issue1, m1);
        chk({nm, ".issue2"}, bus.issue2, m2);
        chk({nm, ".stall"}, bus.stall, mstall);
        chk({nm, ".stall_cnt"}, {1'b0, bus.stall_cnt}, scnt);
        if (m2) chk({nm, ".to_odd"}, bus.issue2_to_odd, modd);
        @(posedge clk);
        model_advance();
        #1;
    endtask

    function automatic slot_t rand_slot();
        return mk($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)),
                  7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endfunction

    vec_t  vecs [10];
    slot_t idle, prod, rdr, w20, r20;

    initial begin
        idle = mk(0, 3'd0, 7'd0, 0, 4'd0, 7'd0, 0, 7'd0, 0, 7'd0, 0);
        drive(idle, idle, 1'b0);

        // s1, s2, flush, issue1, issue2, to_odd, stall
        vecs[0] = '{mk(1, 3'd0, 7'd5, 1, 4'd2, 7'd0, 0, 7'd0, 0, 7'd0, 0),
                    mk(1, 3'd5, 7'd6, 1, 4'd3, 7'd0, 0, 7'd0, 0, 7'd0, 0), 0, 1, 1, 1, 0};
        vecs[1] = '{mk(1, 3'd5, 7'd1, 1, 4'd2, 7'd0, 0, 7'd0, 0, 7'd0, 0),
                    mk(1, 3'd5, 7'd2, 1, 4'd2, 7'd0, 0, 7'd0, 0, 7'd0, 0), 0, 1, 0, 0, 0};
        vecs[2] = '{mk(1, 3'd0, 7'd3, 1, 4'd1, 7'd0, 0, 7'd0, 0, 7'd0, 0),
                    mk(1, 3'd6, 7'd4, 1, 4'd1, 7'd3, 1, 7'd0, 0, 7'd0, 0), 0, 1, 0, 0, 0};
        vecs[3] = '{vecs[0].s1, vecs[0].s2, 1, 0, 0, 0, 0};
        vecs[4] = '{mk(1, 3'd0, 7'd9, 1, 4'd2, 7'd0, 0, 7'd0, 0, 7'd0, 0),
                    mk(1, 3'd7, 7'd9, 1, 4'd3, 7'd0, 0, 7'd0, 0, 7'd0, 0), 0, 1, 0, 0, 0};
        vecs[5] = '{mk(0, 3'd0, 7'd9, 1, 4'd2, 7'd0, 0, 7'd0, 0, 7'd0, 0),
                    mk(1, 3'd5, 7'd8, 1, 4'd3, 7'd0, 0, 7'd0, 0, 7'd0, 0), 0, 0, 0, 0, 0};
        vecs[6] = '{mk(1, 3'd1, 7'd9, 1, 4'd2, 7'd0, 0, 7'd0, 0, 7'd0, 0),
                    mk(0, 3'd5, 7'd8, 1, 4'd3, 7'd0, 0, 7'd0, 0, 7'd0, 0), 0, 1, 0, 0, 0};
        vecs[7] = '{mk(1, 3'd2, 7'd11, 1, 4'd4, 7'd0, 0, 7'd0, 0, 7'd0, 0),
                    mk(1, 3'd6, 7'd12, 1, 4'd1, 7'd11, 0, 7'd0, 0, 7'd0, 0), 0, 1, 1, 1, 0};
        vecs[8] = '{mk(1, 3'd5, 7'd4, 0, 4'd4, 7'd0, 0, 7'd0, 0, 7'd0, 0),
                    mk(1, 3'd2, 7'd12, 1, 4'd1, 7'd4, 1, 7'd0, 0, 7'd0, 0), 0, 1, 1, 0, 0};
        vecs[9] = '{mk(1, 3'd3, 7'd13, 1, 4'd2, 7'd0, 0, 7'd0, 0, 7'd0, 0),
                    mk(1, 3'd7, 7'd14, 0, 4'd1, 7'd0, 0, 7'd0, 0, 7'd13, 1), 0, 1, 0, 0, 0};

        foreach (rdy[i]) rdy[i] = 0;
        do_reset();
        tick_hand("reset", 0, 0, 0, 0, 0);

        for (int v = 0; v < 10; v++) begin
            do_reset();
            drive(vecs[v].s1, vecs[v].s2, vecs[v].flush);
            tick_hand($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e2, vecs[v].eodd,
                      vecs[v].est, 0);
        end

        prod = mk(1, 3'd0, 7'd10, 1, 4'd6, 7'd0, 0, 7'd0, 0, 7'd0, 0);
        rdr  = mk(1, 3'd1, 7'd0, 0, 4'd1, 7'd10, 1, 7'd0, 0, 7'd0, 0);

        // RAW across cycles: lat 6 producer, reader stalls five cycles.
        do_reset();
        drive(prod, idle, 0);
        tick_hand("raw.t0", 1, 0, 0, 0, 0);
        drive(rdr, idle, 0);
        for (int k = 1; k <= 5; k++) tick_hand($sformatf("raw.t%0d", k), 0, 0, 0, 1, k - 1);
        tick_hand("raw.t6", 1, 0, 0, 0, 5);

        // Flush in the middle of the countdown does not move its end.
        do_reset();
        drive(prod, idle, 0);
        tick_hand("fl.t0", 1, 0, 0, 0, -1);
        drive(rdr, idle, 0);
        tick_hand("fl.t1", 0, 0, 0, 1, -1);
        drive(vecs[0].s1, vecs[0].s2, 1);
        tick_hand("fl.t2", 0, 0, 0, 0, 1);
        drive(rdr, idle, 0);
        for (int k = 3; k <= 5; k++) tick_hand($sformatf("fl.t%0d", k), 0, 0, 0, 1, -1);
        tick_hand("fl.t6", 1, 0, 0, 0, 4);

        // Reset while r10 is mid-countdown makes it ready immediately.
        do_reset();
        drive(prod, idle, 0);
        tick_hand("rst.t0", 1, 0, 0, 0, -1);
        drive(rdr, idle, 0);
        tick_hand("rst.t1", 0, 0, 0, 1, -1);
        tick_hand("rst.t2", 0, 0, 0, 1, 1);
        do_reset();
        tick_hand("rst.after", 1, 0, 0, 0, 0);

        // WAW hold with lat 0 treated as 7: lat 1 rewrite waits until t+6.
        w20 = mk(1, 3'd0, 7'd20, 1, 4'd0, 7'd0, 0, 7'd0, 0, 7'd0, 0);
        r20 = mk(1, 3'd1, 7'd0, 0, 4'd1, 7'd20, 1, 7'd0, 0, 7'd0, 0);
        do_reset();
        drive(w20, idle, 0);
        tick_hand("waw.t0", 1, 0, 0, 0, -1);
        w20.lat = 4'd1;
        drive(w20, idle, 0);
        for (int k = 1; k <= 5; k++) tick_hand($sformatf("waw.t%0d", k), 0, 0, 0, 1, -1);
        tick_hand("waw.t6", 1, 0, 0, 0, 5);
        drive(r20, idle, 0);
        tick_hand("waw.t7", 1, 0, 0, 0, 5);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(rand_slot(), rand_slot(), $urandom_range(0, 7) == 0);
            tick_model(i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
